// File: rtl/pos_sweep_sequencer_if.sv
// Bundle between the sweep sequencer and its environment: the start/done handshake,
// the expected masks and unit outputs in, and the shared input vector and results out.
interface pos_sweep_sequencer_if #(
    parameter int NUM_FUNCS = 5
);
    logic                     start;
    logic [16*NUM_FUNCS-1:0]  maxterms;
    logic [NUM_FUNCS-1:0]     f_in;
    logic                     x;
    logic                     y;
    logic                     w;
    logic                     z;
    logic [2:0]               func_sel;
    logic [3:0]               idx;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [7:0]               err_count;
    logic                     err_valid;
    logic [2:0]               first_err_func;
    logic [3:0]               first_err_idx;

    modport master (
        output start, maxterms, f_in,
        input  x, y, w, z, func_sel, idx, busy, done, pass,
               err_count, err_valid, first_err_func, first_err_idx
    );

    modport slave (
        input  start, maxterms, f_in,
        output x, y, w, z, func_sel, idx, busy, done, pass,
               err_count, err_valid, first_err_func, first_err_idx
    );
endinterface

// File: rtl/pos_sweep_sequencer.sv
// Sweeps the shared 4-bit input vector across every product-of-sums unit, compares each
// sampled output with its maxterm mask and reports error count, first failure and pass.
module pos_sweep_sequencer #(
    parameter int NUM_FUNCS = 5,
    parameter int SETTLE    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pos_sweep_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [2:0] LAST_FUNC   = 3'(NUM_FUNCS - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] func_q, func_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_valid_q, err_valid_d;
    logic [2:0] ferr_func_q, ferr_func_d;
    logic [3:0] ferr_idx_q, ferr_idx_d;

    logic [15:0] unit_mask;
    logic        unit_out;
    logic        expected;
    logic        mismatch;

    // Pick the mask slice and output bit of the unit currently under test.
    always_comb begin
        unit_mask = '0;
        unit_out  = 1'b0;
        for (int f = 0; f < NUM_FUNCS; f++) begin
            if (func_q == 3'(f)) begin
                unit_mask = bus.maxterms[16*f +: 16];
                unit_out  = bus.f_in[f];
            end
        end
        expected = ~unit_mask[idx_q];
        mismatch = (unit_out != expected);
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        func_d      = func_q;
        err_cnt_d   = err_cnt_q;
        err_valid_d = err_valid_q;
        ferr_func_d = ferr_func_q;
        ferr_idx_d  = ferr_idx_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_SETTLE;
                    cnt_d       = SETTLE_LOAD;
                    idx_d       = '0;
                    func_d      = '0;
                    err_cnt_d   = '0;
                    err_valid_d = 1'b0;
                    ferr_func_d = '0;
                    ferr_idx_d  = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                    if (!err_valid_q) begin
                        err_valid_d = 1'b1;
                        ferr_func_d = func_q;
                        ferr_idx_d  = idx_q;
                    end
                end
                if (idx_q != 4'd15) begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end else if (func_q != LAST_FUNC) begin
                    idx_d   = '0;
                    func_d  = func_q + 3'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
    // reset is synchronous, so it is simply the highest-priority branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            func_q      <= '0;
            err_cnt_q   <= '0;
            err_valid_q <= 1'b0;
            ferr_func_q <= '0;
            ferr_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            func_q      <= func_d;
            err_cnt_q   <= err_cnt_d;
            err_valid_q <= err_valid_d;
            ferr_func_q <= ferr_func_d;
            ferr_idx_q  <= ferr_idx_d;
        end
    end

    // The vector is the registered index, so {x,y,w,z} can never disagree with idx.
    assign bus.x              = idx_q[3];
    assign bus.y              = idx_q[2];
    assign bus.w              = idx_q[1];
    assign bus.z              = idx_q[0];
    assign bus.idx            = idx_q;
    assign bus.func_sel       = func_q;
    assign bus.busy           = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = (state_q == ST_DONE) && (err_cnt_q == 8'd0);
    assign bus.err_count      = err_cnt_q;
    assign bus.err_valid      = err_valid_q;
    assign bus.first_err_func = ferr_func_q;
    assign bus.first_err_idx  = ferr_idx_q;
endmodule
